// File: rtl/pkg_serial_arith.sv
// pkg_serial_arith: shared types and limits for the bit-serial arithmetic blocks.
package pkg_serial_arith;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/module_bit_full_subtractor.sv
// module_bit_full_subtractor: one-bit full subtractor cell, diff = a - b - borrow_in.
module module_bit_full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic borrow_i,
    output logic diff_o,
    output logic borrow_o
);

    assign diff_o   = a_i ^ b_i ^ borrow_i;
    assign borrow_o = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_i);

endmodule

// File: rtl/module_serial_subtractor.sv
// module_serial_subtractor: LSB-first bit-serial a - b with valid/ready on both sides.
// Optional macro SERIAL_SUB_OVERFLOW_EN builds the signed overflow flag; otherwise overflow_o is 0.
module module_serial_subtractor
    import pkg_serial_arith::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             overflow_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sub_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic             bw_q, borrow_q;
    logic             bit_d, bw_d, last_bit, accept;

    module_bit_full_subtractor u_fs (
        .a_i      (a_q[0]),
        .b_i      (b_q[0]),
        .borrow_i (bw_q),
        .diff_o   (bit_d),
        .borrow_o (bw_d)
    );

    assign accept   = valid_i & ready_o;
    assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE && valid_i) ? RUN  :
                  last_bit                     ? DONE :
                  (state_q == DONE && ready_i) ? IDLE : state_q;
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
    end

    // Difference bits shift into the vacated top of a_q; diff_q only updates on the last bit so outputs hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            bw_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a_i;
            b_q   <= b_i;
            bw_q  <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            a_q   <= {bit_d, a_q[WIDTH-1:1]};
            b_q   <= {1'b0, b_q[WIDTH-1:1]};
            bw_q  <= bw_d;
            cnt_q <= cnt_q + 1'b1;
            if (last_bit) begin
                diff_q   <= {bit_d, a_q[WIDTH-1:1]};
                borrow_q <= bw_d;
            end
        end
    end

    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb_q, b_msb_q, ovf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_msb_q <= a_i[WIDTH-1];
            b_msb_q <= b_i[WIDTH-1];
        end else if (last_bit) begin
            ovf_q <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
        end
    end

    assign overflow_o = ovf_q;
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_module_serial_subtractor.sv
// tb_module_serial_subtractor: scoreboard bench for the serial subtractor, WIDTH = 8.
module tb_module_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bw;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_i = 1'b0;
    logic         ready_i = 1'b1;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         ready_o, valid_o, borrow_o, overflow_o;
    logic [W-1:0] diff_o;

    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    module_serial_subtractor #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .diff_o     (diff_o),
        .borrow_o   (borrow_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] r;
        exp_t e;
        r = {1'b0, a} - {1'b0, b};
        e.d  = r[W-1:0];
        e.bw = r[W];
`ifdef SERIAL_SUB_OVERFLOW_EN
        e.ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
`else
        e.ov = 1'b0;
`endif
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        valid_i = 1'b1;
        a_i = a;
        b_i = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid_o && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({ready_o, valid_o, diff_o, borrow_o, overflow_o} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b diff=%h bw=%b ov=%b, need 1 0 00 0 0",
                     ready_o, valid_o, diff_o, borrow_o, overflow_o);
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] as[3] = '{8'd200, 8'd5, 8'h80};
        logic [W-1:0] bs[3] = '{8'd55, 8'd10, 8'h01};
        exp_t r;
        int lat;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(as[i], bs[i]);
            wait_valid(lat);
            r = sb.pop_front();
            vectors++;
            if (lat !== W) begin
                errors++;
                $display("FAIL directed%0d latency: got %0d edges, need %0d", i, lat, W);
            end
            vectors++;
            if ({valid_o, diff_o, borrow_o, overflow_o} !== {1'b1, r.d, r.bw, r.ov}) begin
                errors++;
                $display("FAIL directed%0d result: vld=%b diff=%h bw=%b ov=%b, need 1 %h %b %b",
                         i, valid_o, diff_o, borrow_o, overflow_o, r.d, r.bw, r.ov);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        exp_t r;
        int lat;
        ready_i = 1'b0;
        send(8'h3C, 8'h5A);
        wait_valid(lat);
        r = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({valid_o, ready_o, diff_o, borrow_o, overflow_o} !== {1'b1, 1'b0, r.d, r.bw, r.ov}) begin
                errors++;
                $display("FAIL backpressure cyc%0d: vld=%b rdy=%b diff=%h bw=%b ov=%b, need 1 0 %h %b %b",
                         i, valid_o, ready_o, diff_o, borrow_o, overflow_o, r.d, r.bw, r.ov);
            end
            @(negedge clk);
        end
        ready_i = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ready_o, valid_o, diff_o, borrow_o} !== {1'b1, 1'b0, r.d, r.bw}) begin
            errors++;
            $display("FAIL release: rdy=%b vld=%b diff=%h bw=%b, need 1 0 %h %b",
                     ready_o, valid_o, diff_o, borrow_o, r.d, r.bw);
        end
    endtask

    task automatic test_ignore_valid;
        exp_t r;
        int lat;
        bit seen;
        ready_i = 1'b1;
        send(8'd100, 8'd37);
        repeat (2) @(negedge clk);
        valid_i = 1'b1;
        a_i = 8'hFF;
        b_i = 8'h00;
        repeat (2) @(negedge clk);
        valid_i = 1'b0;
        wait_valid(lat);
        r = sb.pop_front();
        vectors++;
        if ({valid_o, diff_o, borrow_o, overflow_o} !== {1'b1, r.d, r.bw, r.ov}) begin
            errors++;
            $display("FAIL ignore_valid result: vld=%b diff=%h bw=%b ov=%b, need 1 %h %b %b",
                     valid_o, diff_o, borrow_o, overflow_o, r.d, r.bw, r.ov);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL ignore_valid extra: got a spurious result, need none");
        end
    endtask

    task automatic test_mid_reset;
        exp_t r;
        int lat;
        ready_i = 1'b1;
        send(8'h12, 8'h34);
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({ready_o, valid_o, diff_o, borrow_o} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b vld=%b diff=%h bw=%b, need 1 0 00 0",
                     ready_o, valid_o, diff_o, borrow_o);
        end
        send(8'h00, 8'h00);
        wait_valid(lat);
        r = sb.pop_front();
        vectors++;
        if ({valid_o, diff_o, borrow_o, overflow_o} !== {1'b1, r.d, r.bw, r.ov}) begin
            errors++;
            $display("FAIL after_reset: vld=%b diff=%h bw=%b ov=%b, need 1 %h %b %b",
                     valid_o, diff_o, borrow_o, overflow_o, r.d, r.bw, r.ov);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        exp_t r;
        int lat;
        int last_cyc = 0;
        ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            wait_valid(lat);
            r = sb.pop_front();
            vectors++;
            if ({valid_o, diff_o, borrow_o, overflow_o} !== {1'b1, r.d, r.bw, r.ov}) begin
                errors++;
                $display("FAIL b2b%0d result: vld=%b diff=%h bw=%b ov=%b, need 1 %h %b %b",
                         i, valid_o, diff_o, borrow_o, overflow_o, r.d, r.bw, r.ov);
            end
            if (i > 0) begin
                vectors++;
                if (cyc - last_cyc !== W + 2) begin
                    errors++;
                    $display("FAIL b2b%0d throughput: got %0d cycles, need %0d", i, cyc - last_cyc, W + 2);
                end
            end
            last_cyc = cyc;
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_directed;
        test_backpressure;
        test_ignore_valid;
        test_mid_reset;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
